// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch-state enum and opcode/funct codes
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INS  = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2a;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
import cpu_pkg::*;

module ifid_reg #(
    parameter logic [XLEN-1:0] BUBBLE_INS = cpu_pkg::NOP_INS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] ins_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // A bubble leaves pc untouched; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins   <= BUBBLE_INS;
            pc    <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            ins   <= BUBBLE_INS;
            valid <= 1'b0;
        end else if (load) begin
            ins   <= ins_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, next-PC select, halt FSM, IF/ID register; FETCH_STATS_EN adds fetch/bubble counters
import cpu_pkg::*;

module if_stage #(
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int              IMEM_AW  = 10,
    parameter logic [XLEN-1:0] NOP_INS  = cpu_pkg::NOP_INS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               halt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    ins_id,
    output logic [XLEN-1:0]    pc_id,
    output logic               valid_id,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    fetch_state_t state;
    logic         running;
    logic         ifid_load;
    logic         ifid_bubble;

    assign running     = (state == FS_RUN);
    assign ifid_bubble = running & (redirect | halt);
    assign ifid_load   = running & ~redirect & ~halt & ~stall;
    assign imem_addr   = pc[IMEM_AW-1:0];

    // A redirect beats a halt: the halting syscall in ID is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FS_RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            case (state)
                FS_RUN: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (halt) begin
                        state  <= FS_HALTED;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc + 32'd1;
                    end
                end
                default: begin
                    state  <= FS_HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (running) begin
            if (redirect || (!halt && stall))
                bubble_cnt <= bubble_cnt + 32'd1;
            else if (ifid_load)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

    ifid_reg #(
        .BUBBLE_INS(NOP_INS)
    ) u_ifid_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .ins_in (imem_rdata),
        .pc_in  (pc),
        .ins    (ins_id),
        .pc     (pc_id),
        .valid  (valid_id)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a rule-level fetch model
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ins_id;
    logic [31:0] pc_id;
    logic        valid_id;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    logic [31:0] mem [1024];

    logic [31:0] m_pc, m_ins, m_pc_id, m_fetch, m_bubble;
    logic        m_valid, m_halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .ins_id      (ins_id),
        .pc_id       (pc_id),
        .valid_id    (valid_id),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // Apply one cycle of controls; the model follows the priority list rst > redirect > halt > stall > normal.
    task automatic advance(input logic r, input logic s, input logic rd,
                           input logic [31:0] rpc, input logic h);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
        if (r) begin
            m_pc = RST_PC; m_ins = NOP; m_pc_id = 0; m_valid = 0; m_halted = 0;
            m_fetch = 0; m_bubble = 0;
        end else if (!m_halted) begin
            if (rd) begin
                m_pc = rpc; m_ins = NOP; m_valid = 0; m_bubble = m_bubble + 1;
            end else if (h) begin
                m_ins = NOP; m_valid = 0; m_halted = 1;
            end else if (s) begin
                m_bubble = m_bubble + 1;
            end else begin
                m_ins = mem[m_pc[9:0]]; m_pc_id = m_pc; m_pc = m_pc + 1;
                m_valid = 1; m_fetch = m_fetch + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        advance(1, 0, 0, 0, 0);
        advance(1, 0, 0, 0, 0);
        rst = 0;
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
        checks++; if (ins_id !== NOP) begin errors++; $display("FAIL reset_ins got=%h exp=%h", ins_id, NOP); end
        checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL reset_pc_id got=%h exp=0", pc_id); end
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_id); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_free_run;
        for (int i = 0; i < 4; i++) begin
            advance(0, 0, 0, 0, 0);
            checks++; if (ins_id !== 32'h1000_0000 + i) begin errors++; $display("FAIL run_ins%0d got=%h exp=%h", i, ins_id, 32'h1000_0000 + i); end
            checks++; if (pc_id !== i) begin errors++; $display("FAIL run_pc_id%0d got=%h exp=%h", i, pc_id, i); end
            checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL run_valid%0d got=%b exp=1", i, valid_id); end
        end
    endtask

    task automatic test_stall;
        advance(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'd5) begin errors++; $display("FAIL stall_pre_pc got=%h exp=5", pc); end
        for (int i = 0; i < 2; i++) begin
            advance(0, 1, 0, 0, 0);
            checks++; if (pc !== 32'd5) begin errors++; $display("FAIL stall_pc%0d got=%h exp=5", i, pc); end
            checks++; if (ins_id !== 32'h1000_0004) begin errors++; $display("FAIL stall_ins%0d got=%h exp=10000004", i, ins_id); end
            checks++; if (pc_id !== 32'd4) begin errors++; $display("FAIL stall_pc_id%0d got=%h exp=4", i, pc_id); end
        end
        advance(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'd6) begin errors++; $display("FAIL stall_release_pc got=%h exp=6", pc); end
    endtask

    task automatic test_redirect;
        advance(0, 0, 0, 0, 0);
        advance(0, 0, 1, 32'h40, 0);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL redir_pc got=%h exp=40", pc); end
        checks++; if (ins_id !== NOP) begin errors++; $display("FAIL redir_ins got=%h exp=%h", ins_id, NOP); end
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", valid_id); end
        advance(0, 0, 0, 0, 0);
        checks++; if (ins_id !== 32'h1000_0040) begin errors++; $display("FAIL redir_next_ins got=%h exp=10000040", ins_id); end
        checks++; if (pc_id !== 32'h40) begin errors++; $display("FAIL redir_next_pc_id got=%h exp=40", pc_id); end
    endtask

    task automatic test_redirect_stall;
        advance(0, 1, 1, 32'h80, 0);
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL rs_pc got=%h exp=80", pc); end
        checks++; if (valid_id !== 1'b0 || ins_id !== NOP) begin errors++; $display("FAIL rs_bubble got=%b/%h exp=0/%h", valid_id, ins_id, NOP); end
    endtask

    task automatic test_halt;
        advance(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) advance(0, 0, 0, 0, 0);
        advance(0, 0, 0, 0, 1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (pc !== 32'd9) begin errors++; $display("FAIL halt_pc got=%h exp=9", pc); end
        checks++; if (ins_id !== NOP || valid_id !== 1'b0) begin errors++; $display("FAIL halt_bubble got=%h/%b exp=%h/0", ins_id, valid_id, NOP); end
        for (int i = 0; i < 10; i++) begin
            advance(0, 1'($urandom_range(0, 1)), i[0], $urandom, 1'($urandom_range(0, 1)));
            checks++;
            if (pc !== 32'd9 || halted !== 1'b1 || valid_id !== 1'b0 || ins_id !== NOP) begin
                errors++; $display("FAIL halt_frozen%0d got pc=%h h=%b v=%b ins=%h exp pc=9 h=1 v=0", i, pc, halted, valid_id, ins_id);
            end
        end
        advance(1, 0, 0, 0, 0);
        checks++; if (pc !== RST_PC || halted !== 1'b0) begin errors++; $display("FAIL halt_reset got pc=%h h=%b exp pc=%h h=0", pc, halted, RST_PC); end
    endtask

    task automatic test_redirect_halt_wrap;
        advance(0, 0, 0, 0, 0);
        advance(0, 0, 1, 32'hFFFF_FFFF, 1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rh_halted got=%b exp=0", halted); end
        checks++; if (pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rh_pc got=%h exp=ffffffff", pc); end
        advance(0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        checks++; if (ins_id !== 32'h1000_03FF || pc_id !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ifid got=%h/%h exp=100003ff/ffffffff", ins_id, pc_id); end
`ifdef FETCH_STATS_EN
        checks++; if (fetch_cnt !== m_fetch) begin errors++; $display("FAIL fetch_cnt got=%0d exp=%0d", fetch_cnt, m_fetch); end
        checks++; if (bubble_cnt !== m_bubble) begin errors++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, m_bubble); end
`endif
    endtask

    task automatic test_random;
        logic r, s, rd, h;
        logic [31:0] rpc;
        advance(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 29) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            advance(r, s, rd, rpc, h);
            checks++;
            if (pc !== m_pc || imem_addr !== m_pc[9:0] || valid_id !== m_valid || ins_id !== m_ins ||
                halted !== m_halted || (m_valid && pc_id !== m_pc_id)) begin
                errors++;
                $display("FAIL rand%0d got pc=%h v=%b ins=%h pcid=%h h=%b exp pc=%h v=%b ins=%h pcid=%h h=%b",
                         i, pc, valid_id, ins_id, pc_id, halted, m_pc, m_valid, m_ins, m_pc_id, m_halted);
            end
`ifdef FETCH_STATS_EN
            checks++;
            if (fetch_cnt !== m_fetch || bubble_cnt !== m_bubble) begin
                errors++; $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d", i, fetch_cnt, bubble_cnt, m_fetch, m_bubble);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        m_pc = 0; m_ins = 0; m_pc_id = 0; m_fetch = 0; m_bubble = 0; m_valid = 0; m_halted = 0;
        test_reset;
        test_free_run;
        test_stall;
        test_redirect;
        test_redirect_stall;
        test_halt;
        test_redirect_halt_wrap;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
